avr_dmem_arbiter: RTL and testbench
===================================

// Module: avr_dmem_arbiter
// PURPOSE
// - Shares the single-port AVR data SRAM between the CPU load/store/stack path and one
//   auxiliary master (debug or DMA).
// - Sits between avr_cpu (d_addr/data/data_write) and the SRAM.
// - The CPU has fixed priority. A starvation counter forces one aux slot and stalls the
//   CPU for that cycle; cpu_stall ORs into the CPU stall path.
// PARAMETERS
// - AW        16  address width
// - DW        8   data width
// - MAX_WAIT  4   max cycles aux_req may wait while the CPU holds the bus (>=1)
// PORTS
// - CLK        in   1   clock, all state on rising edge
// - RST_N      in   1   asynchronous active-low reset
// - cpu_req    in   1   CPU accesses data memory this cycle
// - cpu_addr   in   AW  CPU address
// - cpu_we     in   1   1=write, 0=read
// - cpu_wdata  in   DW  CPU write data
// - cpu_rdata  out  DW  CPU read data, cycle after the read slot
// - cpu_stall  out  1   CPU slot lost this cycle; CPU must hold PC/instr and retry
// - aux_req    in   1   aux request; addr/we/wdata held stable until aux_gnt
// - aux_addr   in   AW  aux address
// - aux_we     in   1   aux write enable
// - aux_wdata  in   DW  aux write data
// - aux_gnt    out  1   aux slot taken this cycle (combinational)
// - aux_rvalid out  1   aux read data valid (one cycle after read grant)
// - aux_rdata  out  DW  aux read data
// - mem_addr   out  AW  SRAM address
// - mem_we     out  1   SRAM write strobe, sampled at CLK
// - mem_wdata  out  DW  SRAM write data
// - mem_rdata  in   DW  SRAM read data, 1-cycle latency
// BEHAVIOUR
// - Reset (RST_N=0, async):
//   - wait_cnt=0, rd_owner=NONE, cpu_rdata_q=0, aux_rdata_q=0.
//   - All outputs 0: mem_we=0, aux_gnt=0, cpu_stall=0, aux_rvalid=0.
// - Slot decision, combinational, one access per cycle:
//   - aux_win = aux_req & (~cpu_req | wait_cnt==MAX_WAIT).
//   - aux_gnt = aux_win.
//   - cpu_stall = cpu_req & aux_win.
//   - mem_* driven from aux_* if aux_win, else from cpu_*.
//   - mem_we = winner_req & winner_we. mem_we=0 when no request.
// - Starvation counter wait_cnt (width clog2(MAX_WAIT+1)):
//   - Clears on aux_gnt or when aux_req=0.
//   - Otherwise increments, saturating at MAX_WAIT.
//   - Worst-case aux latency is MAX_WAIT+1 cycles; the CPU loses at most 1 slot per MAX_WAIT+1.
// - Read-return FSM rd_owner {NONE, CPU_RD, AUX_RD}, registered each cycle:
//   - CPU_RD if this slot is a CPU read.
//   - AUX_RD if this slot is an aux read.
//   - NONE for writes or idle.
// - Read return, based on rd_owner:
//   - CPU_RD: cpu_rdata = mem_rdata (passthrough) and is captured into cpu_rdata_q.
//   - Otherwise cpu_rdata = cpu_rdata_q (holds the last CPU read).
//   - AUX_RD: aux_rvalid = 1 and aux_rdata = mem_rdata, captured into aux_rdata_q.
//   - Otherwise aux_rvalid = 0 and aux_rdata = aux_rdata_q.
// - Boundaries:
//   - Both idle: mem_we=0, mem_addr=cpu_addr.
//   - Simultaneous req, wait_cnt<MAX_WAIT: CPU wins and aux_gnt=0.
//   - aux_req deasserted before grant: counter clears and no access occurs.
//   - Write then read to the same address in consecutive slots: read returns the new data
//     (SRAM write-first not required; the slots are distinct cycles).
//   - Reset mid-read: no aux_rvalid pulse after RST_N rises.
//   - MAX_WAIT=1: aux wins every second cycle under continuous CPU traffic.
// STRUCTURE
// - Shared package avr_pkg:
//   - rd_owner_t enum {RD_NONE, RD_CPU, RD_AUX}.
//   - Localparams AVR_DW=8, AVR_AW=16.
// - One sub-module: avr_starve_cnt (param MAX, ports CLK, RST_N, wait_i, clr_i, sat_o).
// - Slot mux, rd_owner FSM and return registers stay in the top module.
// TESTING
// - Reset: hold RST_N=0 with cpu_req=1 and aux_req=1 -> all outputs 0. Release: first
//   cycle gives CPU the slot if wait_cnt=0.
// - CPU only: write 0x5A to 0x0100, then read 0x0100 -> mem_we=1 in cycle 0;
//   cpu_rdata=0x5A in cycle 2; cpu_stall=0 throughout.
// - Aux only: aux read 0x0200 (SRAM=0xC3) -> aux_gnt=1 in the same cycle;
//   next cycle aux_rvalid=1 and aux_rdata=0xC3.
// - Starvation: cpu_req=1 continuously, aux_req=1 from t0, MAX_WAIT=4 ->
//   aux_gnt=1 and cpu_stall=1 at t4 only; CPU owns t0-t3 and t5+.
// - Mixed return: CPU read A=0x11, then aux read B=0x22 in the next cycle ->
//   cpu_rdata=0x11, then aux_rvalid with 0x22, and cpu_rdata still holds 0x11.
// - Async reset asserted the cycle after an aux read grant -> aux_rvalid stays 0;
//   rd_owner=NONE after release.

Source files
------------

// File: rtl/avr_pkg.sv
// ----------------------------------------------------------------------------
// avr_pkg
// Shared definitions for the AVR data-memory arbitration slice.
//   AVR_DW      default data width
//   AVR_AW      default address width
//   rd_owner_t  which master owns the read data returning from the SRAM
//               in the current cycle
// ----------------------------------------------------------------------------
package avr_pkg;

    localparam int AVR_DW = 8;
    localparam int AVR_AW = 16;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_CPU  = 2'd1,
        RD_AUX  = 2'd2
    } rd_owner_t;

endpackage

// File: rtl/avr_starve_cnt.sv
// ----------------------------------------------------------------------------
// avr_starve_cnt
// Saturating wait counter for the auxiliary master. It counts the cycles an
// aux request has been pending without a grant and flags when the limit is
// reached so the arbiter can force one aux slot.
// Ports:
//   CLK     in   clock, rising edge
//   RST_N   in   asynchronous active-low reset
//   wait_i  in   aux request pending this cycle (count enable)
//   clr_i   in   clear the counter (grant taken or request withdrawn)
//   sat_o   out  counter has reached MAX
// ----------------------------------------------------------------------------
module avr_starve_cnt #(
    parameter int MAX = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic wait_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int            CW    = (MAX < 1) ? 1 : $clog2(MAX + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX);

    logic [CW-1:0] wait_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wait_cnt <= '0;
        end else if (clr_i) begin
            wait_cnt <= '0;
        end else if (wait_i && (wait_cnt != MAX_C)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign sat_o = (wait_cnt == MAX_C);

endmodule

// File: rtl/avr_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// avr_dmem_arbiter
// Shares the single-port AVR data SRAM between the CPU load/store/stack path
// and one auxiliary master (debug or DMA). The CPU has fixed priority; a
// starvation counter forces one aux slot after MAX_WAIT lost cycles, stalling
// the CPU for that one cycle.
// Ports:
//   CLK, RST_N                         clock, async active-low reset
//   cpu_req/addr/we/wdata   in         CPU access request
//   cpu_rdata               out        CPU read data (cycle after read slot)
//   cpu_stall               out        CPU lost its slot this cycle
//   aux_req/addr/we/wdata   in         aux request, held until aux_gnt
//   aux_gnt                 out        aux slot taken this cycle
//   aux_rvalid/aux_rdata    out        aux read return (cycle after grant)
//   mem_addr/we/wdata       out        SRAM command
//   mem_rdata               in         SRAM read data, 1-cycle latency
// ----------------------------------------------------------------------------
module avr_dmem_arbiter
    import avr_pkg::*;
#(
    parameter int AW       = AVR_AW,
    parameter int DW       = AVR_DW,
    parameter int MAX_WAIT = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_we,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          aux_req,
    input  logic [AW-1:0] aux_addr,
    input  logic          aux_we,
    input  logic [DW-1:0] aux_wdata,
    output logic          aux_gnt,
    output logic          aux_rvalid,
    output logic [DW-1:0] aux_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic      aux_sat;
    logic      aux_win;
    rd_owner_t rd_owner;
    rd_owner_t rd_owner_nxt;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] aux_rdata_q;

    // Counter clears on a grant or when the request is withdrawn, so a
    // master that gives up never carries stale priority into its next request.
    avr_starve_cnt #(
        .MAX (MAX_WAIT)
    ) u_starve_cnt (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .wait_i (aux_req),
        .clr_i  (aux_win | ~aux_req),
        .sat_o  (aux_sat)
    );

    assign aux_win   = aux_req & (~cpu_req | aux_sat);
    assign aux_gnt   = aux_win;
    assign cpu_stall = cpu_req & aux_win;

    assign mem_addr  = aux_win ? aux_addr  : cpu_addr;
    assign mem_wdata = aux_win ? aux_wdata : cpu_wdata;
    assign mem_we    = aux_win ? aux_we    : (cpu_req & cpu_we);

    always_comb begin
        rd_owner_nxt = RD_NONE;
        if (aux_win) begin
            if (!aux_we) rd_owner_nxt = RD_AUX;
        end else if (cpu_req && !cpu_we) begin
            rd_owner_nxt = RD_CPU;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_owner    <= RD_NONE;
            cpu_rdata_q <= '0;
            aux_rdata_q <= '0;
        end else begin
            rd_owner <= rd_owner_nxt;
            if (rd_owner == RD_CPU) cpu_rdata_q <= mem_rdata;
            if (rd_owner == RD_AUX) aux_rdata_q <= mem_rdata;
        end
    end

    // Returning data passes straight through in its return cycle so neither
    // master pays an extra cycle; the held copy covers every other cycle.
    assign cpu_rdata  = (rd_owner == RD_CPU) ? mem_rdata : cpu_rdata_q;
    assign aux_rvalid = (rd_owner == RD_AUX);
    assign aux_rdata  = (rd_owner == RD_AUX) ? mem_rdata : aux_rdata_q;

endmodule

// File: tb/tb_avr_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_avr_dmem_arbiter
// Self-checking bench: a behavioural 1-cycle-latency SRAM, a cycle-by-cycle
// vector table with hand-computed expectations, and directed sequences for
// reset, starvation (MAX_WAIT=4 and a second MAX_WAIT=1 instance) and reset
// during an aux read return.
// ----------------------------------------------------------------------------
module tb_avr_dmem_arbiter;

    logic        CLK;
    logic        RST_N;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_stall;
    logic        aux_req;
    logic [15:0] aux_addr;
    logic        aux_we;
    logic [7:0]  aux_wdata;
    logic        aux_gnt;
    logic        aux_rvalid;
    logic [7:0]  aux_rdata;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    // second instance, MAX_WAIT=1, only arbitration outputs are checked
    logic [7:0]  cpu_rdata1;
    logic        cpu_stall1;
    logic        aux_gnt1;
    logic        aux_rvalid1;
    logic [7:0]  aux_rdata1;
    logic [15:0] mem_addr1;
    logic        mem_we1;
    logic [7:0]  mem_wdata1;

    logic [7:0]  sram [0:65535];

    int n_checks = 0;
    int n_fail   = 0;

    avr_dmem_arbiter #(.AW(16), .DW(8), .MAX_WAIT(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .aux_req(aux_req), .aux_addr(aux_addr), .aux_we(aux_we), .aux_wdata(aux_wdata),
        .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    avr_dmem_arbiter #(.AW(16), .DW(8), .MAX_WAIT(1)) dut1 (
        .CLK(CLK), .RST_N(RST_N),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata1), .cpu_stall(cpu_stall1),
        .aux_req(aux_req), .aux_addr(aux_addr), .aux_we(aux_we), .aux_wdata(aux_wdata),
        .aux_gnt(aux_gnt1), .aux_rvalid(aux_rvalid1), .aux_rdata(aux_rdata1),
        .mem_addr(mem_addr1), .mem_we(mem_we1), .mem_wdata(mem_wdata1), .mem_rdata(8'h00)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (mem_we) sram[mem_addr] <= mem_wdata;
        mem_rdata <= sram[mem_addr];
    end

    typedef struct {
        logic        cr;
        logic [15:0] ca;
        logic        cw;
        logic [7:0]  cd;
        logic        ar;
        logic [15:0] aa;
        logic        aw;
        logic [7:0]  ad;
        logic        gnt;
        logic        stall;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic [7:0]  crd;
        logic        rv;
        logic [7:0]  ard;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t v(
        input logic cr, input logic [15:0] ca, input logic cw, input logic [7:0] cd,
        input logic ar, input logic [15:0] aa, input logic aw, input logic [7:0] ad,
        input logic gnt, input logic stall, input logic we, input logic [15:0] addr,
        input logic [7:0] wd, input logic [7:0] crd, input logic rv, input logic [7:0] ard);
        vec_t r;
        r.cr = cr; r.ca = ca; r.cw = cw; r.cd = cd;
        r.ar = ar; r.aa = aa; r.aw = aw; r.ad = ad;
        r.gnt = gnt; r.stall = stall; r.we = we; r.addr = addr;
        r.wd = wd; r.crd = crd; r.rv = rv; r.ard = ard;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_cpu(input logic r, input logic [15:0] a, input logic w, input logic [7:0] d);
        cpu_req = r; cpu_addr = a; cpu_we = w; cpu_wdata = d;
    endtask

    task automatic drive_aux(input logic r, input logic [15:0] a, input logic w, input logic [7:0] d);
        aux_req = r; aux_addr = a; aux_we = w; aux_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) sram[i] = 8'h00;
        sram[16'h0010] = 8'h77;
        sram[16'h0200] = 8'hC3;
        sram[16'h0300] = 8'h11;
        sram[16'h0400] = 8'h22;

        //     cpu: req addr we wdata     aux: req addr we wdata     exp: gnt stall we addr wdata cpu_rdata rvalid aux_rdata
        vecs[0]  = v(1,16'h0010,0,8'h00, 1,16'h0200,0,8'h00, 0,0,0,16'h0010,8'h00, 8'h00,0,8'h00);
        vecs[1]  = v(0,16'h0ABC,0,8'h00, 1,16'h0200,0,8'h00, 1,0,0,16'h0200,8'h00, 8'h77,0,8'h00);
        vecs[2]  = v(0,16'h0ABC,0,8'h00, 0,16'h0000,0,8'h00, 0,0,0,16'h0ABC,8'h00, 8'h77,1,8'hC3);
        vecs[3]  = v(1,16'h0100,1,8'h5A, 0,16'h0000,0,8'h00, 0,0,1,16'h0100,8'h5A, 8'h77,0,8'hC3);
        vecs[4]  = v(1,16'h0100,0,8'h00, 0,16'h0000,0,8'h00, 0,0,0,16'h0100,8'h00, 8'h77,0,8'hC3);
        vecs[5]  = v(0,16'h0ABC,0,8'h00, 0,16'h0000,0,8'h00, 0,0,0,16'h0ABC,8'h00, 8'h5A,0,8'hC3);
        vecs[6]  = v(1,16'h0300,0,8'h00, 0,16'h0000,0,8'h00, 0,0,0,16'h0300,8'h00, 8'h5A,0,8'hC3);
        vecs[7]  = v(0,16'h0ABC,0,8'h00, 1,16'h0400,0,8'h00, 1,0,0,16'h0400,8'h00, 8'h11,0,8'hC3);
        vecs[8]  = v(0,16'h0ABC,0,8'h00, 0,16'h0000,0,8'h00, 0,0,0,16'h0ABC,8'h00, 8'h11,1,8'h22);
        vecs[9]  = v(0,16'h0ABC,0,8'h00, 1,16'h0500,1,8'h99, 1,0,1,16'h0500,8'h99, 8'h11,0,8'h22);
        vecs[10] = v(0,16'h0ABC,0,8'h00, 1,16'h0500,0,8'h00, 1,0,0,16'h0500,8'h00, 8'h11,0,8'h22);
        vecs[11] = v(0,16'h0ABC,0,8'h00, 0,16'h0000,0,8'h00, 0,0,0,16'h0ABC,8'h00, 8'h11,1,8'h99);
        vecs[12] = v(1,16'h0010,0,8'h00, 1,16'h0600,0,8'h00, 0,0,0,16'h0010,8'h00, 8'h11,0,8'h99);
        vecs[13] = v(1,16'h0010,0,8'h00, 1,16'h0600,0,8'h00, 0,0,0,16'h0010,8'h00, 8'h77,0,8'h99);
        vecs[14] = v(1,16'h0010,0,8'h00, 0,16'h0600,0,8'h00, 0,0,0,16'h0010,8'h00, 8'h77,0,8'h99);
        vecs[15] = v(1,16'h0010,0,8'h00, 1,16'h0600,0,8'h00, 0,0,0,16'h0010,8'h00, 8'h77,0,8'h99);
        vecs[16] = v(1,16'h0010,0,8'h00, 1,16'h0600,0,8'h00, 0,0,0,16'h0010,8'h00, 8'h77,0,8'h99);
        vecs[17] = v(0,16'h0ABC,0,8'h00, 0,16'h0000,0,8'h00, 0,0,0,16'h0ABC,8'h00, 8'h77,0,8'h99);

        // Reset held with both masters requesting
        RST_N = 1'b0;
        drive_cpu(1'b1, 16'h0000, 1'b0, 8'h00);
        drive_aux(1'b1, 16'h0000, 1'b0, 8'h00);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_aux_gnt",    aux_gnt,    1'b0);
        check("rst_cpu_stall",  cpu_stall,  1'b0);
        check("rst_mem_we",     mem_we,     1'b0);
        check("rst_aux_rvalid", aux_rvalid, 1'b0);
        check("rst_cpu_rdata",  cpu_rdata,  8'h00);
        check("rst_aux_rdata",  aux_rdata,  8'h00);
        check("rst_aux_gnt_mw1", aux_gnt1,  1'b0);

        // Vector table: one entry per cycle, reset released with the first entry
        for (int i = 0; i < 18; i++) begin
            @(posedge CLK);
            #1;
            if (i == 0) RST_N = 1'b1;
            drive_cpu(vecs[i].cr, vecs[i].ca, vecs[i].cw, vecs[i].cd);
            drive_aux(vecs[i].ar, vecs[i].aa, vecs[i].aw, vecs[i].ad);
            @(negedge CLK);
            check($sformatf("v%0d_aux_gnt", i),    aux_gnt,    vecs[i].gnt);
            check($sformatf("v%0d_cpu_stall", i),  cpu_stall,  vecs[i].stall);
            check($sformatf("v%0d_mem_we", i),     mem_we,     vecs[i].we);
            check($sformatf("v%0d_mem_addr", i),   mem_addr,   vecs[i].addr);
            check($sformatf("v%0d_mem_wdata", i),  mem_wdata,  vecs[i].wd);
            check($sformatf("v%0d_cpu_rdata", i),  cpu_rdata,  vecs[i].crd);
            check($sformatf("v%0d_aux_rvalid", i), aux_rvalid, vecs[i].rv);
            check($sformatf("v%0d_aux_rdata", i),  aux_rdata,  vecs[i].ard);
        end

        // Starvation: CPU reads every cycle, aux read pending from t0 until granted
        for (int t = 0; t < 7; t++) begin
            @(posedge CLK);
            #1;
            drive_cpu(1'b1, 16'h0010, 1'b0, 8'h00);
            drive_aux((t <= 4), 16'h0200, 1'b0, 8'h00);
            @(negedge CLK);
            check($sformatf("starve_t%0d_aux_gnt", t),   aux_gnt,   (t == 4));
            check($sformatf("starve_t%0d_cpu_stall", t), cpu_stall, (t == 4));
            check($sformatf("starve_t%0d_mem_addr", t),  mem_addr,  (t == 4) ? 16'h0200 : 16'h0010);
            check($sformatf("starve_t%0d_aux_gnt_mw1", t),   aux_gnt1,   (t == 1 || t == 3));
            check($sformatf("starve_t%0d_cpu_stall_mw1", t), cpu_stall1, (t == 1 || t == 3));
            if (t == 5) begin
                check("starve_t5_aux_rvalid", aux_rvalid, 1'b1);
                check("starve_t5_aux_rdata",  aux_rdata,  8'hC3);
            end
        end

        // Async reset the cycle after an aux read grant
        @(posedge CLK);
        #1;
        drive_cpu(1'b0, 16'h0ABC, 1'b0, 8'h00);
        drive_aux(1'b1, 16'h0200, 1'b0, 8'h00);
        @(negedge CLK);
        check("rstrd_aux_gnt", aux_gnt, 1'b1);
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        drive_aux(1'b0, 16'h0000, 1'b0, 8'h00);
        #1;
        check("rstrd_rvalid_asserted", aux_rvalid, 1'b0);
        @(negedge CLK);
        check("rstrd_aux_rdata_in_rst", aux_rdata, 8'h00);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(negedge CLK);
        check("rstrd_rvalid_after_rel", aux_rvalid, 1'b0);
        check("rstrd_cpu_rdata_after_rel", cpu_rdata, 8'h00);
        check("rstrd_aux_rdata_after_rel", aux_rdata, 8'h00);
        @(posedge CLK);
        @(negedge CLK);
        check("rstrd_rvalid_later", aux_rvalid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
